// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M execute unit: funct3 codes, FSM encoding and
// operand-class helpers. Build option MULDIV_DIV_EN enables the iterative divider.
package muldiv_pkg;

   localparam int XLEN_DEFAULT = 32;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } muldiv_state_e;

   // rs1 is treated as signed by MULH, MULHSU, DIV and REM; rs2 by MULH, DIV and REM.
   function automatic logic aSigned(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic bSigned(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic isMulHigh(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
   endfunction

   function automatic logic isDivOp(input logic [2:0] f3);
      return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
   endfunction

   function automatic logic isRemOp(input logic [2:0] f3);
      return (f3 == F3_REM) || (f3 == F3_REMU);
   endfunction

endpackage

// File: rtl/divider_core.sv
// Iterative radix-2 restoring divider on unsigned magnitudes, one quotient bit per step.
// quotient/remainder show the value after the current step; they are final when last_iter is high.
module divider_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            last_iter
);

   localparam int CW = $clog2(XLEN);

   logic [XLEN-1:0] quoReg;
   logic [XLEN-1:0] remReg;
   logic [XLEN-1:0] divReg;
   logic [CW-1:0]   cnt;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   // quoReg starts as the dividend and fills with quotient bits from the right.
   assign shifted   = {remReg, quoReg[XLEN-1]};
   assign diff      = shifted - {1'b0, divReg};
   assign quotient  = {quoReg[XLEN-2:0], ~diff[XLEN]};
   assign remainder = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
   assign last_iter = step && (cnt == CW'(XLEN - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         quoReg <= '0;
         remReg <= '0;
         divReg <= '0;
         cnt    <= '0;
      end else if (load) begin
         quoReg <= dividend;
         remReg <= '0;
         divReg <= divisor;
         cnt    <= '0;
      end else if (step) begin
         quoReg <= quotient;
         remReg <= remainder;
         cnt    <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute unit: pipelined multiplier, optional iterative divider, stall/done FSM.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops finish at once with result 0.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int MUL_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            startE,
   input  logic [2:0]      funct3E,
   input  logic [XLEN-1:0] SrcAE,
   input  logic [XLEN-1:0] SrcBE,
   input  logic            FlushE,
   output logic            stall_req,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output muldiv_state_e   stateDbg
);

   muldiv_state_e state, stateNext;

   logic [2:0]        opReg;
   logic [2:0]        mulCnt;
   logic              startIdle;
   logic              mulLast;
   logic [2*XLEN-1:0] mulA;
   logic [2*XLEN-1:0] mulB;
   logic [2*XLEN-1:0] product;
   logic [2*XLEN-1:0] mulPipe [MUL_STAGES];
   logic [XLEN-1:0]   mulResult;
   logic              divFast;
   logic              divLast;
   logic [XLEN-1:0]   fastResult;
   logic [XLEN-1:0]   divResult;

   assign startIdle = (state == IDLE) && startE;

   // Sign-extending to 2*XLEN makes the low 2*XLEN bits of a plain product
   // correct for every signedness combination.
   assign mulA    = {{XLEN{aSigned(funct3E) & SrcAE[XLEN-1]}}, SrcAE};
   assign mulB    = {{XLEN{bSigned(funct3E) & SrcBE[XLEN-1]}}, SrcBE};
   assign product = mulA * mulB;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MUL_STAGES; i++) mulPipe[i] <= '0;
      end else if (startIdle || (state == MUL)) begin
         mulPipe[0] <= product;
         for (int i = 1; i < MUL_STAGES; i++) mulPipe[i] <= mulPipe[i-1];
      end
   end

   assign mulLast   = (mulCnt == 3'(MUL_STAGES - 1));
   assign mulResult = isMulHigh(opReg) ? mulPipe[MUL_STAGES-1][2*XLEN-1:XLEN]
                                       : mulPipe[MUL_STAGES-1][XLEN-1:0];

`ifdef MULDIV_DIV_EN
   logic            divSignA;
   logic            divSignB;
   logic            divLoad;
   logic            negQ;
   logic            negR;
   logic [XLEN-1:0] minNeg;
   logic [XLEN-1:0] dividendMag;
   logic [XLEN-1:0] divisorMag;
   logic [XLEN-1:0] quotient;
   logic [XLEN-1:0] remainder;

   assign divSignA    = aSigned(funct3E) & SrcAE[XLEN-1];
   assign divSignB    = bSigned(funct3E) & SrcBE[XLEN-1];
   assign dividendMag = divSignA ? -SrcAE : SrcAE;
   assign divisorMag  = divSignB ? -SrcBE : SrcBE;
   assign minNeg      = {1'b1, {(XLEN-1){1'b0}}};

   // Divide-by-zero and the signed overflow case have fixed answers; skip iteration.
   assign divFast    = (SrcBE == '0) || (aSigned(funct3E) && (SrcAE == minNeg) && (SrcBE == '1));
   assign fastResult = (SrcBE == '0) ? (isRemOp(funct3E) ? SrcAE : '1)
                                     : (isRemOp(funct3E) ? '0 : SrcAE);
   assign divLoad    = startIdle && isDivOp(funct3E) && !divFast;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         negQ <= 1'b0;
         negR <= 1'b0;
      end else if (divLoad) begin
         negQ <= divSignA ^ divSignB;
         negR <= divSignA;
      end
   end

   divider_core #(.XLEN(XLEN)) uDivider (
      .clk       (clk),
      .reset     (reset),
      .load      (divLoad),
      .step      (state == DIV),
      .dividend  (dividendMag),
      .divisor   (divisorMag),
      .quotient  (quotient),
      .remainder (remainder),
      .last_iter (divLast)
   );

   assign divResult = isRemOp(opReg) ? (negR ? -remainder : remainder)
                                     : (negQ ? -quotient : quotient);
`else
   assign divFast    = 1'b1;
   assign fastResult = '0;
   assign divLast    = 1'b0;
   assign divResult  = '0;
`endif

   always_comb begin
      stateNext = state;
      case (state)
         IDLE: begin
            if (startE) begin
               if (!isDivOp(funct3E)) stateNext = MUL;
               else if (divFast)      stateNext = DONE;
               else                   stateNext = DIV;
            end
         end
         MUL: begin
            if (FlushE)       stateNext = IDLE;
            else if (mulLast) stateNext = DONE;
         end
         DIV: begin
            if (FlushE)       stateNext = IDLE;
            else if (divLast) stateNext = DONE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // result only moves on entry to DONE, so a flush leaves the previous value intact.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         opReg  <= '0;
         mulCnt <= '0;
         result <= '0;
      end else begin
         state <= stateNext;
         if (startIdle) opReg <= funct3E;
         if (state == MUL) mulCnt <= mulCnt + 3'd1;
         else              mulCnt <= '0;
         if (stateNext == DONE) begin
            case (state)
               MUL:     result <= mulResult;
               DIV:     result <= divResult;
               default: result <= fastResult;
            endcase
         end
      end
   end

   assign stall_req = startIdle || (state == MUL) || (state == DIV);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign stateDbg  = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32, MUL_STAGES=2) with a result scoreboard.
// Expectations follow the MULDIV_DIV_EN setting of the build.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN       = 32;
   localparam int MUL_STAGES = 2;
`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic          clk     = 1'b0;
   logic          reset   = 1'b0;
   logic          startE  = 1'b0;
   logic [2:0]    funct3E = 3'b000;
   logic [31:0]   SrcAE   = '0;
   logic [31:0]   SrcBE   = '0;
   logic          FlushE  = 1'b0;
   logic          stall_req;
   logic          busy;
   logic          done;
   logic [31:0]   result;
   muldiv_state_e stateDbg;

   logic [31:0] exp_q[$];
   int nChecks = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
      .clk       (clk),
      .reset     (reset),
      .startE    (startE),
      .funct3E   (funct3E),
      .SrcAE     (SrcAE),
      .SrcBE     (SrcBE),
      .FlushE    (FlushE),
      .stall_req (stall_req),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .stateDbg  (stateDbg)
   );

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] divOrZero(input logic [31:0] v);
      return DIV_EN ? v : 32'h0;
   endfunction

   function automatic logic [31:0] refOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        up;
      logic signed [63:0] sp;
      logic signed [65:0] su;
      int                 sa;
      int                 sb;
      logic               ovf;
      up  = {32'h0, a} * {32'h0, b};
      sp  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      su  = $signed({{34{a[31]}}, a}) * $signed({34'h0, b});
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         F3_MUL:    return up[31:0];
         F3_MULH:   return sp[63:32];
         F3_MULHSU: return su[63:32];
         F3_MULHU:  return up[63:32];
         F3_DIV:    return divOrZero((b == 0) ? 32'hFFFF_FFFF : ovf ? a : sa / sb);
         F3_DIVU:   return divOrZero((b == 0) ? 32'hFFFF_FFFF : a / b);
         F3_REM:    return divOrZero((b == 0) ? a : ovf ? 32'h0 : sa % sb);
         default:   return divOrZero((b == 0) ? a : a % b);
      endcase
   endfunction

   function automatic int refLat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      if (!f3[2]) return MUL_STAGES + 1;
      if (!DIV_EN) return 1;
      if (b == 0) return 1;
      if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 1;
   endfunction

   // Called at a falling edge; presents the instruction until the cycle after DONE.
   task automatic runOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expRes, input int expLat);
      int          cyc;
      int          stallCnt;
      logic        got;
      logic [31:0] expV;
      startE  = 1'b1;
      funct3E = f3;
      SrcAE   = a;
      SrcBE   = b;
      exp_q.push_back(expRes);
      #1;
      checkBit({tag, "_stall_start"}, stall_req, 1'b1);
      cyc      = 0;
      stallCnt = 1;
      got      = 1'b0;
      while (!got && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done) got = 1'b1;
         else if (stall_req) stallCnt++;
      end
      checkBit({tag, "_done_seen"}, got, 1'b1);
      expV = exp_q.pop_front();
      check32({tag, "_result"}, result, expV);
      check32({tag, "_latency"}, cyc, expLat);
      check32({tag, "_stall_cycles"}, stallCnt, expLat);
      checkBit({tag, "_stall_in_done"}, stall_req, 1'b0);
      @(negedge clk);
      checkBit({tag, "_idle_after"}, busy, 1'b0);
      startE = 1'b0;
      check32({tag, "_held"}, result, expV);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic        doneSeen;

      // Reset state
      repeat (2) @(negedge clk);
      checkBit("rst_busy", busy, 1'b0);
      checkBit("rst_done", done, 1'b0);
      checkBit("rst_stall", stall_req, 1'b0);
      check32("rst_result", result, 32'h0);
      check32("rst_state", 32'(stateDbg), 32'(IDLE));
      reset = 1'b1;
      @(negedge clk);

      // Multiply
      runOp("mul", F3_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 3);
      runOp("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
      runOp("mulh", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3);
      runOp("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);

      // Divide and fast paths
      runOp("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, divOrZero(32'hFFFF_FFFD), DIV_EN ? 33 : 1);
      runOp("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, divOrZero(32'hFFFF_FFFF), DIV_EN ? 33 : 1);
      runOp("divu_by0", F3_DIVU, 32'd5, 32'd0, divOrZero(32'hFFFF_FFFF), 1);
      runOp("remu_by0", F3_REMU, 32'd5, 32'd0, divOrZero(32'd5), 1);
      runOp("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, divOrZero(32'h8000_0000), 1);
      runOp("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

`ifdef MULDIV_DIV_EN
      // Flush during iteration 10 of a divide
      startE  = 1'b1;
      funct3E = F3_DIVU;
      SrcAE   = 32'd1000;
      SrcBE   = 32'd7;
      repeat (10) @(negedge clk);
      checkBit("flushdiv_busy_before", busy, 1'b1);
      FlushE = 1'b1;
      startE = 1'b0;
      @(negedge clk);
      FlushE = 1'b0;
      checkBit("flushdiv_busy_after", busy, 1'b0);
      doneSeen = done;
      repeat (30) begin
         @(negedge clk);
         if (done) doneSeen = 1'b1;
      end
      checkBit("flushdiv_no_done", doneSeen, 1'b0);
`endif
      runOp("mul_after_flush", F3_MUL, 32'd3, 32'd4, 32'd12, 3);

      // Flush in the last multiply cycle wins over completion
      startE  = 1'b1;
      funct3E = F3_MUL;
      SrcAE   = 32'd9;
      SrcBE   = 32'd9;
      repeat (2) @(negedge clk);
      FlushE = 1'b1;
      startE = 1'b0;
      @(negedge clk);
      FlushE = 1'b0;
      checkBit("flushmul_done", done, 1'b0);
      checkBit("flushmul_busy", busy, 1'b0);
      check32("flushmul_result_kept", result, 32'd12);

      // Random operations against the reference model
      for (int i = 0; i < 10; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = ((i % 4) == 0) ? 32'h0 : $urandom;
         if (i == 5) begin
            f3 = F3_DIV;
            a  = 32'h8000_0000;
            b  = 32'hFFFF_FFFF;
         end
         if (i == 6) b = 32'd3;
         runOp($sformatf("rnd%0d", i), f3, a, b, refOp(f3, a, b), refLat(f3, a, b));
      end

      runOp("mul_pre_reset", F3_MUL, 32'd3, 32'd4, 32'd12, 3);

      // Asynchronous reset in the middle of an operation
      startE  = 1'b1;
      funct3E = DIV_EN ? F3_DIVU : F3_MUL;
      SrcAE   = 32'd1000;
      SrcBE   = 32'd3;
      @(negedge clk);
      checkBit("rstmid_busy_before", busy, 1'b1);
      #2;
      startE = 1'b0;
      reset  = 1'b0;
      #1;
      checkBit("rstmid_busy", busy, 1'b0);
      checkBit("rstmid_stall", stall_req, 1'b0);
      checkBit("rstmid_done", done, 1'b0);
      check32("rstmid_result", result, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      runOp("divu_after_reset", F3_DIVU, 32'd100, 32'd7, divOrZero(32'd14), DIV_EN ? 33 : 1);

      check32("scoreboard_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
